ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000: clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for ps2_clk and ps2_data; minimum 2.
REQ-003 clk  in  1: single system clock; all state on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 ps2_clk  in  1: raw PS/2 clock from pad, asynchronous to clk.
REQ-006 ps2_data  in  1: raw PS/2 data from pad, asynchronous to clk.
REQ-007 code_valid  out  1: one-cycle pulse; a complete scancode is available.
REQ-008 code  out  8: last decoded scancode byte, prefixes excluded.
REQ-009 is_ext  out  1: code was preceded by 0xE0; valid with code_valid.
REQ-010 is_break  out  1: code was preceded by 0xF0; valid with code_valid.
REQ-011 frame_err  out  1: one-cycle pulse on a bad start, stop or parity bit, or on timeout.
REQ-012 key_left, key_right, key_fire  out  1 each: held-key levels for E0 6B, E0 74 and 29 respectively.

Function
REQ-013 Both pad inputs SHALL pass through SYNC_STAGES flops; a falling edge is previous synced ps2_clk = 1 and current = 0.
REQ-014 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL advance only on a detected falling edge.
REQ-015 IDLE: a falling edge with data = 0 enters DATA; with data = 1, set frame_err and stay in IDLE.
REQ-016 DATA: shift 8 bits LSB first with a 3-bit counter; after bit 7, go to PARITY.
REQ-017 PARITY: capture the bit and go to STOP; a frame is correct when its data plus parity bits hold an odd number of ones.
REQ-018 STOP: data = 1 with correct parity yields an internal byte strobe one cycle later; otherwise pulse frame_err; always return to IDLE.
REQ-019 A watchdog counter SHALL reset on every falling edge and count only outside IDLE.
REQ-020 On reaching TIMEOUT_CYCLES-1 the watchdog SHALL return the FSM to IDLE, pulse frame_err, and clear the prefix flags.
REQ-021 A byte of 0xE0 SHALL set ext_pend and a byte of 0xF0 SHALL set brk_pend; neither raises code_valid.
REQ-022 Any other byte SHALL pulse code_valid one cycle after the byte strobe and drive code, is_ext = ext_pend and is_break = brk_pend.
REQ-023 Both pending flags SHALL clear in the cycle code_valid is pulsed.
REQ-024 Latency from the stop-bit edge-detect cycle to code_valid SHALL be exactly 2 clk cycles.
REQ-025 On code_valid matching a game key, the matching key_* level is set to !is_break; other codes leave key_* unchanged.
REQ-026 An is_ext mismatch is not a game key; for example, 0x6B without E0 SHALL NOT change key_left.
REQ-027 If a timeout coincides with the stop-bit edge, the timeout wins: no byte strobe is produced.
REQ-028 code, is_ext and is_break SHALL hold their values between pulses.

Reset
REQ-029 While rst_n = 0, all outputs SHALL be 0, with code = 0x00, and the FSM SHALL be in IDLE.
REQ-030 While rst_n = 0, the synchronizers SHALL be set to 1 (bus idle), and the watchdog and pending flags SHALL be cleared.
REQ-031 A reset during a frame SHALL discard the frame without a frame_err pulse; the next full frame decodes normally.

Configuration
REQ-032 With PS2_PARITY_CHECK_EN defined, a parity mismatch SHALL pulse frame_err and suppress the byte (REQ-018).
REQ-033 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored; only start, stop and timeout raise frame_err.

Structure
REQ-034 Package ps2_pkg SHALL hold the frame FSM state enum and the constants SC_EXT = 8'hE0, SC_BRK = 8'hF0, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74 and SC_FIRE = 8'h29.
REQ-035 Sub-module ps2_frame_rx SHALL own the synchronizers, edge detect, frame FSM, watchdog and byte strobe.
REQ-036 The top level SHALL own prefix tracking and the key-state registers.

Verification
REQ-037 Frame 0x29 with parity 0 and stop 1 -> code_valid after 2 cycles, code = 0x29, is_ext = 0, is_break = 0, key_fire = 1.
REQ-038 Frames F0 then 29 -> a single code_valid, is_break = 1, code = 0x29, key_fire = 0; no pulse for the F0 byte.
REQ-039 Frames E0 6B then E0 F0 6B -> key_left goes 1 then 0, with is_ext = 1 on both pulses; key_right stays 0.
REQ-040 Frame 0x74 with parity 1 (wrong) -> frame_err pulse and no code_valid under PS2_PARITY_CHECK_EN; code_valid with code = 0x74 without the macro.
REQ-041 Send start plus 4 bits, then idle for TIMEOUT_CYCLES -> one frame_err pulse; the following 0x29 frame decodes correctly.
REQ-042 Assert rst_n low after 5 bits of a frame -> all outputs 0 and no frame_err; the following E0 74 frame gives key_right = 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: frame FSM states and scancodes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_FIRE  = 8'h29;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pad synchronizers, falling-edge detect, frame FSM, watchdog.
// Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q;
  logic [7:0]   shift_q;
  logic         parity_q;
  logic [WD_W-1:0] wd_q;
  logic         strobe_d;
  logic         err_d;
  logic         frame_ok;
  logic         par_ok;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  assign timeout   = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign frame_ok  = ^{shift_q, parity_q};
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok    = frame_ok;
`else
  // Parity is still captured and evaluated, it just never gates the byte.
  assign par_ok    = 1'b1 | frame_ok;
`endif
  assign byte_data = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Timeout takes priority over any coincident edge, including the stop bit.
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE:   if (!data_s) state_d = DATA;
                else         err_d   = 1'b1;
        DATA:   if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (data_s && par_ok) strobe_d = 1'b1;
          else                  err_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= strobe_d;
      frame_err   <= err_d;
      if (state_q == IDLE || fall || timeout) wd_q <= '0;
      else                                    wd_q <= wd_q + 1'b1;
      if (fall && !timeout) begin
        case (state_q)
          IDLE:   bit_cnt_q <= '0;
          DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          PARITY: parity_q <= data_s;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: E0/F0 prefix tracking and held-key levels for game keys.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_break,
  output logic       frame_err,
  output logic       key_left,
  output logic       key_right,
  output logic       key_fire
);

  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       rx_timeout;
  logic       ext_pend;
  logic       brk_pend;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_strobe(rx_strobe),
    .byte_data  (rx_byte),
    .frame_err  (frame_err),
    .timeout    (rx_timeout)
  );

  // Key levels update on the same edge that raises code_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_valid <= 1'b0;
      code       <= '0;
      is_ext     <= 1'b0;
      is_break   <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_fire   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (rx_strobe) begin
        if (rx_byte == SC_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          code_valid <= 1'b1;
          code       <= rx_byte;
          is_ext     <= ext_pend;
          is_break   <= brk_pend;
          ext_pend   <= 1'b0;
          brk_pend   <= 1'b0;
          if (rx_byte == SC_LEFT  &&  ext_pend) key_left  <= !brk_pend;
          if (rx_byte == SC_RIGHT &&  ext_pend) key_right <= !brk_pend;
          if (rx_byte == SC_FIRE  && !ext_pend) key_fire  <= !brk_pend;
        end
      end
      if (rx_timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table of frames plus timeout and reset sequences.
module tb_ps2_key_decoder;

  localparam int unsigned TMO  = 200;
  localparam int          HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_valid;
  logic [7:0] code;
  logic       is_ext, is_break, frame_err;
  logic       key_left, key_right, key_fire;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_valid(code_valid), .code(code), .is_ext(is_ext), .is_break(is_break),
    .frame_err(frame_err), .key_left(key_left), .key_right(key_right), .key_fire(key_fire)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cv_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err)  err_cnt++;
  end

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    int         exp_cv;
    int         exp_err;
    logic [7:0] exp_code;
    logic       exp_ext, exp_brk, exp_left, exp_right, exp_fire;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sends the first n bits of a frame; lat = negedges from stop-bit fall to code_valid.
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n, output int lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    lat = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= HALF; k++) begin
          @(negedge clk);
          if (code_valid && lat == 0) lat = k;
        end
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Full frame with checks of pulses, held outputs and key levels.
  task automatic frame_check(input string tag, input vec_t v);
    int cv0, err0, lat;
    cv0 = cv_cnt;
    err0 = err_cnt;
    send_bits(v.b, v.bad_par, 11, lat);
    check({tag, ".cv"},    cv_cnt - cv0,   v.exp_cv);
    check({tag, ".err"},   err_cnt - err0, v.exp_err);
    check({tag, ".code"},  code,      v.exp_code);
    check({tag, ".ext"},   is_ext,    v.exp_ext);
    check({tag, ".brk"},   is_break,  v.exp_brk);
    check({tag, ".left"},  key_left,  v.exp_left);
    check({tag, ".right"}, key_right, v.exp_right);
    check({tag, ".fire"},  key_fire,  v.exp_fire);
    // two synchronizer stages plus the two-cycle decode latency
    if (v.exp_cv == 1) check({tag, ".lat"}, lat, 4);
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic bp, input int cv, input int er,
                              input logic [7:0] c, input logic e, input logic k,
                              input logic l, input logic r, input logic f);
    vec_t v;
    v.b = b; v.bad_par = bp; v.exp_cv = cv; v.exp_err = er; v.exp_code = c;
    v.exp_ext = e; v.exp_brk = k; v.exp_left = l; v.exp_right = r; v.exp_fire = f;
    return v;
  endfunction

  initial begin
    int cv0, err0, lat;

    vecs[0]  = mk(8'h29, 0, 1, 0, 8'h29, 0, 0, 0, 0, 1);
    vecs[1]  = mk(8'hF0, 0, 0, 0, 8'h29, 0, 0, 0, 0, 1);
    vecs[2]  = mk(8'h29, 0, 1, 0, 8'h29, 0, 1, 0, 0, 0);
    vecs[3]  = mk(8'hE0, 0, 0, 0, 8'h29, 0, 1, 0, 0, 0);
    vecs[4]  = mk(8'h6B, 0, 1, 0, 8'h6B, 1, 0, 1, 0, 0);
    vecs[5]  = mk(8'h6B, 0, 1, 0, 8'h6B, 0, 0, 1, 0, 0);
    vecs[6]  = mk(8'hE0, 0, 0, 0, 8'h6B, 0, 0, 1, 0, 0);
    vecs[7]  = mk(8'hF0, 0, 0, 0, 8'h6B, 0, 0, 1, 0, 0);
    vecs[8]  = mk(8'h6B, 0, 1, 0, 8'h6B, 1, 1, 0, 0, 0);
    vecs[9]  = mk(8'hE0, 0, 0, 0, 8'h6B, 1, 1, 0, 0, 0);
    vecs[10] = mk(8'h74, 0, 1, 0, 8'h74, 1, 0, 0, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
    vecs[11] = mk(8'h74, 1, 0, 1, 8'h74, 1, 0, 0, 1, 0);
`else
    vecs[11] = mk(8'h74, 1, 1, 0, 8'h74, 0, 0, 0, 1, 0);
`endif
    vecs[12] = mk(8'h29, 0, 1, 0, 8'h29, 0, 0, 0, 1, 1);

    repeat (5) @(negedge clk);
    check("reset.outs",
          {code_valid, code, is_ext, is_break, frame_err, key_left, key_right, key_fire}, '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 13; i++) frame_check($sformatf("vec%0d", i), vecs[i]);

    // Prefix then an abandoned frame: timeout must pulse once and drop the prefix.
    send_bits(8'hE0, 0, 11, lat);
    cv0 = cv_cnt;
    err0 = err_cnt;
    send_bits(8'h55, 0, 5, lat);
    repeat (TMO + 50) @(negedge clk);
    check("tmo.err", err_cnt - err0, 1);
    check("tmo.cv",  cv_cnt - cv0,   0);
    frame_check("tmo.after", mk(8'h29, 0, 1, 0, 8'h29, 0, 0, 0, 1, 1));

    // Reset in the middle of a frame discards it silently.
    err0 = err_cnt;
    send_bits(8'hAA, 0, 5, lat);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.outs",
          {code_valid, code, is_ext, is_break, frame_err, key_left, key_right, key_fire}, '0);
    rst_n = 1'b1;
    repeat (TMO + 20) @(negedge clk);
    check("rst.err", err_cnt - err0, 0);
    frame_check("rst.e0", mk(8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    frame_check("rst.74", mk(8'h74, 0, 1, 0, 8'h74, 1, 0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
